ram_ctl_decode: RTL and testbench

RAM_CTL_DECODE -- requirements
Module: ram_ctl_decode

---
 rtl/ram_ctl_decode_pkg.sv | 17 +
 rtl/pet_addr_decode.sv | 29 ++
 rtl/ram_ctl_decode.sv | 111 +++++++++++
 tb/tb_ram_ctl_decode.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctl_decode_pkg.sv
// Shared types and constants for the SRAM Wishbone controller and the PET I/O page decoder.
package ram_ctl_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_DONE = 2'd3
  } ram_state_e;

  localparam logic [7:0] IO_PAGE       = 8'hE8;
  localparam int         PIA1_BIT      = 4;
  localparam int         PIA2_BIT      = 5;
  localparam int         VIA_BIT       = 6;
  localparam int         MAX_WB_CYCLES = 3;

endpackage

// File: rtl/pet_addr_decode.sv
// Combinational chip-select decode of the CPU address: the $E8xx page is I/O, everything else RAM.
module pet_addr_decode
  import ram_ctl_decode_pkg::*;
#(
  parameter int CPU_ADDR_WIDTH = 16
) (
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i,
  output logic                      ram_en_o,
  output logic                      pia1_en_o,
  output logic                      pia2_en_o,
  output logic                      via_en_o,
  output logic                      io_en_o
);

  logic io_page;
  logic unused_addr_bits;

  assign io_page   = (cpu_addr_i[15:8] == IO_PAGE);

  // Select bits are independent; several chips may respond at once.
  assign io_en_o   = io_page;
  assign ram_en_o  = !io_page;
  assign pia1_en_o = io_page & cpu_addr_i[PIA1_BIT];
  assign pia2_en_o = io_page & cpu_addr_i[PIA2_BIT];
  assign via_en_o  = io_page & cpu_addr_i[VIA_BIT];

  assign unused_addr_bits = ^cpu_addr_i;

endmodule

// File: rtl/ram_ctl_decode.sv
// Wishbone B4 pipelined SRAM controller with a fixed three-cycle access, plus the PET address decoder.
module ram_ctl_decode
  import ram_ctl_decode_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int CPU_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      wb_clock_i,
  input  logic                      wb_reset_i,
  input  logic [RAM_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  input  logic                      wb_we_i,
  input  logic                      wb_cycle_i,
  input  logic                      wb_strobe_i,
  output logic                      wb_stall_o,
  output logic                      wb_ack_o,
  output logic                      ram_oe_o,
  output logic                      ram_we_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0]     ram_data_i,
  output logic [DATA_WIDTH-1:0]     ram_data_o,
  output logic                      ram_data_oe,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i,
  output logic                      ram_en_o,
  output logic                      pia1_en_o,
  output logic                      pia2_en_o,
  output logic                      via_en_o,
  output logic                      io_en_o
);

  ram_state_e                state;
  logic                      accept;
  logic [RAM_ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0]     data_p0;
  logic                      we_p0;

  assign accept     = (state == ST_IDLE) & wb_cycle_i & wb_strobe_i;
  assign ram_addr_o = addr_p0;
  assign ram_data_o = data_p0;

  // Request capture: address, data and direction held for the whole access
  always_ff @(posedge wb_clock_i) begin
    if (accept) begin
      addr_p0 <= wb_addr_i;
      data_p0 <= wb_data_i;
      we_p0   <= wb_we_i;
    end
  end

  // Access sequencer: every output is registered so the SRAM pins are glitch-free.
  // Once accepted, an access runs to DONE regardless of wb_cycle_i; only reset aborts it.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state       <= ST_IDLE;
      wb_ack_o    <= 1'b0;
      wb_stall_o  <= 1'b0;
      ram_oe_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_data_oe <= 1'b0;
      wb_data_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wb_ack_o <= 1'b0;
          if (accept) begin
            wb_stall_o  <= 1'b1;
            ram_oe_o    <= !wb_we_i;
            ram_data_oe <= wb_we_i;
            state       <= ST_ACC1;
          end
        end
        ST_ACC1: begin
          ram_we_o <= we_p0;
          state    <= ST_ACC2;
        end
        ST_ACC2: begin
          ram_oe_o <= 1'b0;
          ram_we_o <= 1'b0;
          wb_ack_o <= 1'b1;
          if (!we_p0) begin
            wb_data_o <= ram_data_i;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          wb_ack_o    <= 1'b0;
          wb_stall_o  <= 1'b0;
          ram_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  pet_addr_decode #(
    .CPU_ADDR_WIDTH(CPU_ADDR_WIDTH)
  ) u_decode (
    .cpu_addr_i(cpu_addr_i),
    .ram_en_o  (ram_en_o),
    .pia1_en_o (pia1_en_o),
    .pia2_en_o (pia2_en_o),
    .via_en_o  (via_en_o),
    .io_en_o   (io_en_o)
  );

endmodule

// File: tb/tb_ram_ctl_decode.sv
// Bench for ram_ctl_decode: directed scenarios plus random traffic against a transaction-level model.
module tb_ram_ctl_decode;
  import ram_ctl_decode_pkg::*;

  localparam int RAW = 17;
  localparam int CAW = 16;
  localparam int DW  = 8;

  logic           clk;
  logic           rst;
  logic [RAW-1:0] addr;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;
  logic           we;
  logic           cyc;
  logic           stb;
  logic           stall;
  logic           ack;
  logic           ram_oe;
  logic           ram_we;
  logic [RAW-1:0] ram_addr;
  logic [DW-1:0]  ram_din;
  logic [DW-1:0]  ram_dout;
  logic           ram_doe;
  logic [CAW-1:0] cpu_addr;
  logic           ram_en, pia1_en, pia2_en, via_en, io_en;

  ram_ctl_decode #(
    .RAM_ADDR_WIDTH(RAW),
    .CPU_ADDR_WIDTH(CAW),
    .DATA_WIDTH    (DW)
  ) dut (
    .wb_clock_i (clk),
    .wb_reset_i (rst),
    .wb_addr_i  (addr),
    .wb_data_i  (wdata),
    .wb_data_o  (rdata),
    .wb_we_i    (we),
    .wb_cycle_i (cyc),
    .wb_strobe_i(stb),
    .wb_stall_o (stall),
    .wb_ack_o   (ack),
    .ram_oe_o   (ram_oe),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_data_i (ram_din),
    .ram_data_o (ram_dout),
    .ram_data_oe(ram_doe),
    .cpu_addr_i (cpu_addr),
    .ram_en_o   (ram_en),
    .pia1_en_o  (pia1_en),
    .pia2_en_o  (pia2_en),
    .via_en_o   (via_en),
    .io_en_o    (io_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction model: cycles elapsed since acceptance (0 = no access in flight)
  int            since_acc = 0;
  bit            model_valid = 0;
  logic [RAW-1:0] m_addr;
  logic [DW-1:0]  m_data;
  logic           m_we;
  logic [DW-1:0]  m_rd = '0;

  task automatic model_edge();
    if (rst) begin
      since_acc   = 0;
      m_rd        = '0;
      model_valid = 1;
    end else if (since_acc == 0) begin
      if (cyc && stb) begin
        since_acc = 1;
        m_addr    = addr;
        m_data    = wdata;
        m_we      = we;
      end
    end else begin
      if (since_acc == MAX_WB_CYCLES - 1 && !m_we) m_rd = ram_din;
      since_acc = (since_acc == MAX_WB_CYCLES) ? 0 : since_acc + 1;
    end
  endtask

  task automatic check_outputs();
    logic       pg;
    logic [4:0] dec_exp;
    pg      = (cpu_addr[15:8] == 8'hE8);
    dec_exp = {!pg, pg & cpu_addr[4], pg & cpu_addr[5], pg & cpu_addr[6], pg};
    chk("decode", {27'd0, ram_en, pia1_en, pia2_en, via_en, io_en}, {27'd0, dec_exp});
    if (model_valid) begin
      chk("stall", stall, since_acc != 0);
      chk("ack", ack, since_acc == MAX_WB_CYCLES);
      chk("ram_oe", ram_oe, !m_we && (since_acc == 1 || since_acc == 2));
      chk("ram_we", ram_we, m_we && since_acc == 2);
      chk("ram_data_oe", ram_doe, m_we && since_acc != 0);
      chk("wb_data_o", rdata, m_rd);
      chk("oe_we_excl", ram_oe & ram_we, 1'b0);
      if (since_acc != 0) chk("ram_addr", ram_addr, m_addr);
      if (since_acc != 0 && m_we) chk("ram_data_o", ram_dout, m_data);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  logic [CAW-1:0] dec_addr [7] = '{16'h0000, 16'h8000, 16'hE810, 16'hE820, 16'hE840, 16'hE8FF, 16'hE900};
  logic [4:0]     dec_exp  [7] = '{5'b10000, 5'b10000, 5'b01001, 5'b00101, 5'b00011, 5'b01111, 5'b10000};

  initial begin
    int oe_n, we_n, doe_n, ack_at, ack_at2;
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    ram_din = '0; cpu_addr = '0;
    cycle();
    cycle();
    chk("rst_stall", stall, 1'b0);
    chk("rst_rdata", rdata, 8'h00);

    // Read $01234 returning $5A
    rst = 1'b0; addr = 17'h01234; we = 1'b0; cyc = 1'b1; stb = 1'b1; ram_din = 8'h5A;
    oe_n = 0; ack_at = -1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (k == 1) stb = 1'b0;
      if (k == 1) chk("rd_addr", ram_addr, 17'h01234);
      oe_n += int'(ram_oe);
      if (ack) ack_at = k;
    end
    chk("rd_oe_cycles", oe_n, 2);
    chk("rd_ack_cycle", ack_at, 3);
    chk("rd_data", rdata, 8'h5A);

    // Write $1FFFF = $A5
    addr = 17'h1FFFF; wdata = 8'hA5; we = 1'b1; stb = 1'b1; ram_din = 8'h33;
    we_n = 0; doe_n = 0; ack_at = -1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (k == 1) stb = 1'b0;
      if (k == 2) begin
        chk("wr_we_acc2", ram_we, 1'b1);
        chk("wr_dout", ram_dout, 8'hA5);
      end
      we_n  += int'(ram_we);
      doe_n += int'(ram_doe);
      if (ack) ack_at = k;
    end
    chk("wr_we_cycles", we_n, 1);
    chk("wr_doe_cycles", doe_n, 3);
    chk("wr_ack_cycle", ack_at, 3);
    chk("wr_keeps_rdata", rdata, 8'h5A);

    // Back-to-back strobes: second request accepted in the idle cycle after DONE
    addr = 17'h00100; we = 1'b0; stb = 1'b1; ram_din = 8'hC3;
    ack_at = -1; ack_at2 = -1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k <= 3) chk("b2b_stall", stall, 1'b1);
      if (k == 4) chk("b2b_idle_stall", stall, 1'b0);
      if (k == 4) ram_din = 8'h3C;
      if (k == 5) stb = 1'b0;
      if (ack && ack_at < 0) ack_at = k;
      else if (ack) ack_at2 = k;
    end
    chk("b2b_ack1", ack_at, 3);
    chk("b2b_ack2", ack_at2, 7);
    chk("b2b_rdata", rdata, 8'h3C);

    // Reset asserted during ACC2 aborts the access without ack
    addr = 17'h0ABCD; we = 1'b1; wdata = 8'h77; stb = 1'b1;
    cycle();
    stb = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("abort_ack", ack, 1'b0);
    chk("abort_oe", ram_oe, 1'b0);
    chk("abort_we", ram_we, 1'b0);
    chk("abort_doe", ram_doe, 1'b0);
    chk("abort_stall", stall, 1'b0);
    chk("abort_rdata", rdata, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("abort_no_ack", ack, 1'b0);
    end

    // Decode table
    for (int i = 0; i < 7; i++) begin
      cpu_addr = dec_addr[i];
      #1;
      chk($sformatf("dec_%04h", dec_addr[i]),
          {27'd0, ram_en, pia1_en, pia2_en, via_en, io_en}, {27'd0, dec_exp[i]});
    end

    // Random traffic, including cycle drops mid-access and occasional resets
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      cyc      = ($urandom_range(0, 4) != 0);
      stb      = $urandom_range(0, 1);
      we       = $urandom_range(0, 1);
      addr     = RAW'($urandom());
      wdata    = DW'($urandom());
      ram_din  = DW'($urandom());
      cpu_addr = CAW'($urandom());
      if ($urandom_range(0, 1) == 1) cpu_addr[15:8] = 8'hE8;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
